// File: rtl/instruction_fetcher_if.sv
// Program-memory read channel between the instruction fetcher (master) and
// program memory (slave): one request at a time over a valid/ready handshake.
interface instruction_fetcher_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data
  );
endinterface

// File: rtl/instruction_fetcher.sv
// Per-core instruction fetch unit: IDLE -> FETCHING -> FETCHED, driven by core_state.
// Optional one-entry line buffer enabled by defining FETCH_LINE_BUFFER_EN.
module instruction_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int MEM_TIMEOUT           = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             invalidate,
  instruction_fetcher_if.master            mem,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             fetch_error
);

  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } fetch_state_e;

  fetch_state_e                     state_q;
  logic                             valid_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q;
  logic                             error_q;
  logic [7:0]                       count_q;

  logic                             lb_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] lb_data;

  // A completed memory transfer: request outstanding and memory answering.
  logic capture;
  assign capture = (state_q == FETCHING) && valid_q && mem.mem_read_ready;

`ifdef FETCH_LINE_BUFFER_EN
  logic                             lb_valid_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] lb_tag_q;
  logic [PROGRAM_MEM_DATA_BITS-1:0] lb_data_q;

  // An invalidate in the same cycle must not let stale contents through.
  assign lb_hit  = lb_valid_q && !invalidate && (lb_tag_q == current_pc);
  assign lb_data = lb_data_q;

  // NOTE: only lb_valid_q is reset; tag and data are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      lb_valid_q <= 1'b0;
    end else if (invalidate) begin
      lb_valid_q <= 1'b0;
    end else if (capture) begin
      lb_valid_q <= 1'b1;
      lb_tag_q   <= addr_q;
      lb_data_q  <= mem.mem_read_data;
    end
  end
`else
  logic unused_invalidate;
  assign unused_invalidate = invalidate;
  assign lb_hit            = 1'b0;
  assign lb_data           = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      error_q <= 1'b0;
      count_q <= 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (lb_hit) begin
              instr_q <= lb_data;
              state_q <= FETCHED;
            end else begin
              addr_q  <= current_pc;
              valid_q <= 1'b1;
              count_q <= 8'd0;
              state_q <= FETCHING;
            end
          end
        end
        FETCHING: begin
          // Ready takes priority over the timeout on the final wait cycle.
          if (capture) begin
            instr_q <= mem.mem_read_data;
            valid_q <= 1'b0;
            state_q <= FETCHED;
          end else if (count_q == TIMEOUT_LAST) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b1;
            state_q <= FETCHED;
          end else begin
            count_q <= count_q + 8'd1;
          end
        end
        FETCHED: begin
          if (core_state == CORE_DECODE) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.mem_read_valid   = valid_q;
  assign mem.mem_read_address = addr_q;
  assign fetcher_state        = state_q;
  assign instruction          = instr_q;
  assign fetch_error          = error_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher: directed boundary steps plus
// randomized fetches compared against a transaction-level reference model.
module tb_instruction_fetcher;

  localparam int T = 10;

  localparam logic [2:0] C_FETCH  = 3'b001;
  localparam logic [2:0] C_DECODE = 3'b010;
  localparam logic [2:0] S_IDLE     = 3'b000;
  localparam logic [2:0] S_FETCHING = 3'b001;
  localparam logic [2:0] S_FETCHED  = 3'b010;

`ifdef FETCH_LINE_BUFFER_EN
  localparam bit LB_EN = 1'b1;
`else
  localparam bit LB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        invalidate;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic        fetch_error;

  instruction_fetcher_if #(.ADDR_BITS(8), .DATA_BITS(16)) mem_if ();

  instruction_fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16),
    .MEM_TIMEOUT(T)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .core_state   (core_state),
    .current_pc   (current_pc),
    .invalidate   (invalidate),
    .mem          (mem_if.master),
    .fetcher_state(fetcher_state),
    .instruction  (instruction),
    .fetch_error  (fetch_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: program memory image, sticky error, last delivered word,
  // and the one-entry buffer contents as seen from outside.
  logic [15:0] mem_img [256];
  logic        exp_err;
  logic [15:0] exp_instr;
  logic        lb_valid;
  logic [7:0]  lb_tag;
  logic [15:0] lb_data;
  int          n_requests;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] non_decode_state();
    logic [2:0] v;
    v = 3'($urandom_range(0, 6));
    if (v >= 3'd2) v = v + 3'd1;
    return v;
  endfunction

  // One complete fetch: memory answers after d non-ready cycles (d >= T means
  // it never answers in time); inv_at_capture raises invalidate on the answer.
  task automatic do_fetch(input logic [7:0] pc, input int d, input bit inv_at_capture,
                          input int hold);
    bit hit;
    int k;
    bit done;
    hit = LB_EN && lb_valid && (lb_tag == pc);
    core_state = C_FETCH;
    current_pc = pc;
    invalidate = 1'b0;
    mem_if.mem_read_ready = 1'b0;
    tick();
    core_state = non_decode_state();
    current_pc = 8'($urandom);
    if (hit) begin
      exp_instr = lb_data;
      check("hit_state", 32'(fetcher_state), 32'(S_FETCHED));
      check("hit_valid", 32'(mem_if.mem_read_valid), 32'd0);
      check("hit_instr", 32'(instruction), 32'(exp_instr));
    end else begin
      n_requests++;
      check("req_valid", 32'(mem_if.mem_read_valid), 32'd1);
      check("req_addr", 32'(mem_if.mem_read_address), 32'(pc));
      check("req_state", 32'(fetcher_state), 32'(S_FETCHING));
      k = 0;
      done = 1'b0;
      while (!done) begin
        mem_if.mem_read_ready = (k == d);
        mem_if.mem_read_data  = (k == d) ? mem_img[pc] : 16'($urandom);
        invalidate            = (k == d) ? inv_at_capture : 1'b0;
        tick();
        k++;
        if (k - 1 == d) begin
          exp_instr = mem_img[pc];
          if (inv_at_capture) lb_valid = 1'b0;
          else begin
            lb_valid = 1'b1;
            lb_tag   = pc;
            lb_data  = mem_img[pc];
          end
          done = 1'b1;
        end else if (k == T) begin
          exp_instr = 16'h0000;
          exp_err   = 1'b1;
          done      = 1'b1;
        end else begin
          check("wait_state", 32'(fetcher_state), 32'(S_FETCHING));
          check("wait_valid", 32'(mem_if.mem_read_valid), 32'd1);
          check("wait_addr", 32'(mem_if.mem_read_address), 32'(pc));
        end
      end
      mem_if.mem_read_ready = 1'b0;
      invalidate = 1'b0;
      check("done_state", 32'(fetcher_state), 32'(S_FETCHED));
      check("done_valid", 32'(mem_if.mem_read_valid), 32'd0);
      check("done_instr", 32'(instruction), 32'(exp_instr));
    end
    check("error_flag", 32'(fetch_error), 32'(exp_err));
    // Sit in FETCHED; FETCH seen here must not start a new request.
    for (int h = 0; h < hold; h++) begin
      core_state = ($urandom_range(0, 1) == 0) ? C_FETCH : non_decode_state();
      mem_if.mem_read_ready = 1'($urandom);
      tick();
      check("hold_state", 32'(fetcher_state), 32'(S_FETCHED));
      check("hold_valid", 32'(mem_if.mem_read_valid), 32'd0);
      check("hold_instr", 32'(instruction), 32'(exp_instr));
    end
    mem_if.mem_read_ready = 1'b0;
    core_state = C_DECODE;
    tick();
    core_state = 3'b000;
    check("decode_state", 32'(fetcher_state), 32'(S_IDLE));
    check("decode_instr", 32'(instruction), 32'(exp_instr));
  endtask

  task automatic pulse_invalidate();
    core_state = 3'b000;
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    lb_valid   = 1'b0;
  endtask

  initial begin
    int req_before;
    for (int i = 0; i < 256; i++) mem_img[i] = 16'($urandom);
    mem_img[8'h05] = 16'h3A1F;
    mem_img[8'h40] = 16'hBEEF;
    exp_err = 1'b0; exp_instr = 16'h0000; lb_valid = 1'b0; lb_tag = '0; lb_data = '0;
    n_requests = 0;

    reset = 1'b1; core_state = C_FETCH; current_pc = 8'h12; invalidate = 1'b0;
    mem_if.mem_read_ready = 1'b1; mem_if.mem_read_data = 16'hFFFF;
    tick(); tick();
    check("rst_state", 32'(fetcher_state), 32'(S_IDLE));
    check("rst_valid", 32'(mem_if.mem_read_valid), 32'd0);
    check("rst_addr", 32'(mem_if.mem_read_address), 32'd0);
    check("rst_instr", 32'(instruction), 32'd0);
    check("rst_error", 32'(fetch_error), 32'd0);
    reset = 1'b0; core_state = 3'b000; mem_if.mem_read_ready = 1'b0;
    tick();

    // Zero-wait read, then seven wait states, then ready on the last allowed cycle.
    do_fetch(8'h05, 0, 1'b0, 1);
    do_fetch(8'h10, 7, 1'b0, 0);
    do_fetch(8'h40, T - 1, 1'b0, 0);

    // Line buffer: repeat address, then invalidate and repeat again.
    req_before = n_requests;
    do_fetch(8'h20, 0, 1'b0, 0);
    do_fetch(8'h20, 2, 1'b0, 0);
    check("lb_repeat_requests", 32'(n_requests - req_before), LB_EN ? 32'd1 : 32'd2);
    pulse_invalidate();
    do_fetch(8'h20, 1, 1'b0, 0);
    check("lb_inval_requests", 32'(n_requests - req_before), LB_EN ? 32'd2 : 32'd3);

    // PC wrap, then timeout and stickiness of the error flag.
    do_fetch(8'hFF, 0, 1'b0, 0);
    do_fetch(8'h00, 3, 1'b0, 0);
    do_fetch(8'h55, T + 3, 1'b0, 1);
    do_fetch(8'h56, 0, 1'b0, 0);

    // Reset during FETCHING; a late ready must be ignored.
    core_state = C_FETCH; current_pc = 8'h33;
    tick();
    core_state = 3'b000;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_err = 1'b0; exp_instr = 16'h0000; lb_valid = 1'b0;
    check("mid_rst_state", 32'(fetcher_state), 32'(S_IDLE));
    check("mid_rst_valid", 32'(mem_if.mem_read_valid), 32'd0);
    check("mid_rst_instr", 32'(instruction), 32'd0);
    check("mid_rst_error", 32'(fetch_error), 32'd0);
    mem_if.mem_read_ready = 1'b1; mem_if.mem_read_data = 16'hDEAD;
    tick(); tick();
    mem_if.mem_read_ready = 1'b0;
    check("late_ready_state", 32'(fetcher_state), 32'(S_IDLE));
    check("late_ready_instr", 32'(instruction), 32'd0);

    // Randomized fetches over a small address pool so buffer hits recur.
    for (int n = 0; n < 60; n++) begin
      logic [7:0] pc;
      pc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h20 + 8'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) pulse_invalidate();
      do_fetch(pc, $urandom_range(0, T + 1), ($urandom_range(0, 5) == 0), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
